// File: rtl/seq_alu.sv
// seq_alu: bus-attached sequential ALU with two operand registers (A, B),
// a result register R and carry/zero/negative flags. Ops 0..6 complete in
// one clock. MUL is a WIDTH-iteration shift-and-add that runs from private
// copies of A and B, so the operands and op may change while it runs.
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  inout  wire  [WIDTH-1:0] bus,
  input  logic             load_A,
  input  logic             load_B,
  input  logic             write_A,
  input  logic             write_B,
  input  logic             write_R,
  input  logic [2:0]       op,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             carry,
  output logic             zero,
  output logic             negative
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [WIDTH-1:0]   a_reg, b_reg, r_reg;
  logic               carry_reg, zero_reg, negative_reg;
  logic [2*WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0]   mplier_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [CW-1:0]      count_reg;

  logic [WIDTH-1:0]   alu_r;
  logic               alu_c;
  logic [WIDTH:0]     sum_ext;
  logic [2*WIDTH-1:0] mul_sum;
  logic               mul_last;

  // Single bus driver with fixed priority R > A > B; released otherwise.
  // Purely combinational so a write during clr still shows the live value.
  assign bus = write_R ? r_reg :
               write_A ? a_reg :
               write_B ? b_reg : {WIDTH{1'bz}};

  assign busy     = (state_reg != ST_IDLE);
  assign done     = (state_reg == ST_DONE);
  assign carry    = carry_reg;
  assign zero     = zero_reg;
  assign negative = negative_reg;

  // One shift-and-add step: add the shifted multiplicand when the current
  // multiplier LSB is set. The last step's sum is the full product.
  assign mul_sum  = acc_reg + (mplier_reg[0] ? mcand_reg : {2*WIDTH{1'b0}});
  assign mul_last = (count_reg == CNT_LAST);

  // Single-cycle operations on the registered operands.
  always_comb begin
    alu_r   = '0;
    alu_c   = 1'b0;
    sum_ext = '0;
    case (op)
      3'd0: begin
        sum_ext = {1'b0, a_reg} + {1'b0, b_reg};
        alu_r   = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
      end
      3'd1: begin
        // carry-out of A + ~B + 1 is the "no borrow" indication
        sum_ext = {1'b0, a_reg} + {1'b0, ~b_reg} + (WIDTH+1)'(1);
        alu_r   = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
      end
      3'd2: alu_r = a_reg & b_reg;
      3'd3: alu_r = a_reg | b_reg;
      3'd4: alu_r = a_reg ^ b_reg;
      3'd5: begin
        alu_r = {a_reg[WIDTH-2:0], 1'b0};
        alu_c = a_reg[WIDTH-1];
      end
      3'd6: begin
        alu_r = {1'b0, a_reg[WIDTH-1:1]};
        alu_c = a_reg[0];
      end
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (clr) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic; start only matters in IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) state_next = (op == 3'd7) ? ST_MUL : ST_DONE;
      end
      ST_MUL: begin
        if (mul_last) state_next = ST_DONE;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Operand loads, result/flag updates and multiplier iteration.
  always_ff @(posedge clk) begin
    if (clr) begin
      a_reg        <= '0;
      b_reg        <= '0;
      r_reg        <= '0;
      carry_reg    <= 1'b0;
      zero_reg     <= 1'b0;
      negative_reg <= 1'b0;
      mcand_reg    <= '0;
      mplier_reg   <= '0;
      acc_reg      <= '0;
      count_reg    <= '0;
    end else begin
      if (load_A) a_reg <= bus;
      if (load_B) b_reg <= bus;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            if (op == 3'd7) begin
              mcand_reg  <= {{WIDTH{1'b0}}, a_reg};
              mplier_reg <= b_reg;
              acc_reg    <= '0;
              count_reg  <= '0;
            end else begin
              r_reg        <= alu_r;
              carry_reg    <= alu_c;
              zero_reg     <= (alu_r == '0);
              negative_reg <= alu_r[WIDTH-1];
            end
          end
        end
        ST_MUL: begin
          acc_reg    <= mul_sum;
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          count_reg  <= count_reg + CW'(1);
          if (mul_last) begin
            r_reg        <= mul_sum[WIDTH-1:0];
            carry_reg    <= |mul_sum[2*WIDTH-1:WIDTH];
            zero_reg     <= (mul_sum[WIDTH-1:0] == '0);
            negative_reg <= mul_sum[WIDTH-1];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
